// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding, state width and defaults
// for the UART transmit arbiter (uart_tx_arb, rr_pick).
package uart_arb_pkg;

  localparam int ST_W = 2;

  typedef logic [ST_W-1:0] arb_state_t;

  localparam arb_state_t IDLE      = 2'd0;
  localparam arb_state_t ISSUE     = 2'd1;
  localparam arb_state_t WAIT_RISE = 2'd2;
  localparam arb_state_t WAIT_FALL = 2'd3;

  localparam int BUSY_TIMEOUT_DEF = 16;

  function automatic int id_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority search starting at ptr, wrapping.
// Ports: req (request vector), ptr (start index), any, idx.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  // Walk from the farthest slot back to ptr so the slot
  // closest to ptr is the last (and winning) assignment.
  always_comb begin
    int j;
    logic [W-1:0] c;
    j   = 0;
    c   = '0;
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      c = W'(j);
      if (req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin byte arbiter feeding one UART tx.
// Ports: clk, rst (async high), req_valid/req_data/req_last
// in, req_ready out; uart_wr_en/uart_wr_data out,
// uart_tx_busy in; grant_id, arb_busy status.
// Option: define UART_ARB_LOCK_EN to hold the grant across a
// multi-byte message until a byte with req_last=1.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  localparam int GW          = id_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               uart_wr_en,
  output logic [7:0]         uart_wr_data,
  input  logic               uart_tx_busy,
  output logic [GW-1:0]      grant_id,
  output logic               arb_busy
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t       state;
  logic [GW-1:0]    ptr;
  logic [CW-1:0]    tmo_cnt;
  logic [N_REQ-1:0] elig;
  logic             pick_any;
  logic [GW-1:0]    pick_idx;
  logic [GW-1:0]    pick_nxt;
  logic [N_REQ-1:0] pick_oh;

`ifdef UART_ARB_LOCK_EN
  logic             lock;
  logic [N_REQ-1:0] gmask;

  always_comb begin
    gmask           = '0;
    gmask[grant_id] = 1'b1;
  end

  assign elig = lock ? (req_valid & gmask) : req_valid;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig        = req_valid;
`endif

  rr_pick #(
    .N (N_REQ),
    .W (GW)
  ) u_pick (
    .req (elig),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  assign pick_nxt = (pick_idx == GW'(N_REQ - 1))
                  ? '0 : pick_idx + 1'b1;

  assign arb_busy = (state != IDLE);

  // Strobes, data and last are captured on the grant edge so
  // the requester may move on as soon as req_ready is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      tmo_cnt      <= '0;
      grant_id     <= '0;
      req_ready    <= '0;
      uart_wr_en   <= 1'b0;
      uart_wr_data <= 8'h00;
`ifdef UART_ARB_LOCK_EN
      lock         <= 1'b0;
`endif
    end else begin
      req_ready    <= '0;
      uart_wr_en   <= 1'b0;
      uart_wr_data <= 8'h00;
      unique case (state)
        IDLE: begin
          if (pick_any && !uart_tx_busy) begin
            state        <= ISSUE;
            grant_id     <= pick_idx;
            req_ready    <= pick_oh;
            uart_wr_en   <= 1'b1;
            uart_wr_data <= req_data[{pick_idx, 3'b000} +: 8];
`ifdef UART_ARB_LOCK_EN
            lock <= !req_last[pick_idx];
            if (req_last[pick_idx]) ptr <= pick_nxt;
`else
            ptr <= pick_nxt;
`endif
          end
        end
        ISSUE: begin
          state   <= WAIT_RISE;
          tmo_cnt <= '0;
        end
        WAIT_RISE: begin
          if (uart_tx_busy) begin
            state <= WAIT_FALL;
          end else if (tmo_cnt == CW'(BUSY_TIMEOUT - 1)) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_FALL: begin
          if (!uart_tx_busy) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed scoreboard bench for uart_tx_arb.
// Byte stream checked against expectations queued per step.
module tb_uart_tx_arb;

  localparam int N  = 2;
  localparam int BT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0 = 1'b0, v1 = 1'b0;
  logic       l0 = 1'b1, l1 = 1'b1;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;

  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           uart_wr_en;
  logic [7:0]     uart_wr_data;
  logic           uart_tx_busy;
  logic [0:0]     grant_id;
  logic           arb_busy;

  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};
  assign req_data  = {d1, d0};

  int   mode      = 0;
  logic man_busy  = 1'b0;
  logic auto_busy = 1'b0;
  int   ucnt      = 0;
  bit   uact      = 1'b0;

  assign uart_tx_busy = (mode == 1) ? man_busy : auto_busy;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int rd          = 0;
  int vectors     = 0;
  int miscompares = 0;

  uart_tx_arb #(
    .N_REQ        (N),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_wr_en   (uart_wr_en),
    .uart_wr_data (uart_wr_data),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy)
  );

  // Output capture plus UART model: busy rises 2 cycles
  // after a strobe and stays high for 3 cycles.
  always @(negedge clk) begin
    if (rst) begin
      uact      = 1'b0;
      auto_busy = 1'b0;
    end else begin
      if (uart_wr_en) begin
        got_q.push_back(uart_wr_data);
        ucnt = 0;
        uact = 1'b1;
      end else if (uact) begin
        ucnt++;
      end
      auto_busy = uact && ucnt >= 2 && ucnt < 5;
      if (uact && ucnt >= 5) uact = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(int i, logic [7:0] b, logic last,
                      output int lat);
    int k = 0;
    if (i == 0) begin
      v0 = 1'b1; d0 = b; l0 = last;
    end else begin
      v1 = 1'b1; d1 = b; l1 = last;
    end
    step;
    while (!req_ready[i] && k < 400) begin
      step;
      k++;
    end
    lat = k;
    chk($sformatf("ready%0d_%h", i, b), req_ready[i], 1);
    if (i == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int k = 0;
    while (arb_busy && k < 60) begin
      step;
      k++;
    end
    chk(tag, arb_busy, 0);
  endtask

  task automatic wait_busy(logic val, string tag);
    int k = 0;
    while (uart_tx_busy !== val && k < 20) begin
      step;
      k++;
    end
    chk(tag, uart_tx_busy, val);
  endtask

  task automatic sb_check(string tag);
    logic [7:0]  e;
    logic [31:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd < got_q.size()) ? 32'(got_q[rd]) : 32'hDEAD0000;
      chk($sformatf("%s_%0d", tag, rd), o, 32'(e));
      rd++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    step;
  endtask

  initial begin
    int lat, lat0, lat1, k, n0;

    // reset state
    step;
    step;
    chk("rst_wr_en", uart_wr_en, 0);
    chk("rst_wr_data", uart_wr_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_arb_busy", arb_busy, 0);
    rst = 1'b0;
    step;

    // single request
    exp_q.push_back(8'h41);
    send(0, 8'h41, 1'b1, lat);
    chk("single_lat", lat, 0);
    chk("single_wr_en", uart_wr_en, 1);
    chk("single_data", uart_wr_data, 8'h41);
    chk("single_grant", grant_id, 0);
    step;
    chk("single_wr_off", uart_wr_en, 0);
    chk("single_data_off", uart_wr_data, 0);
    chk("single_rdy_off", req_ready, 0);
    chk("single_arb", arb_busy, 1);
    wait_busy(1'b1, "single_rise");
    wait_busy(1'b0, "single_fall");
    chk("single_hold", arb_busy, 1);
    step;
    chk("single_idle", arb_busy, 0);
    sb_check("single");

    // contention, fresh pointer
    do_reset;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hB0);
    fork
      begin
        send(0, 8'hA0, 1'b1, lat0);
        send(0, 8'hA0, 1'b1, lat0);
      end
      begin
        send(1, 8'hB0, 1'b1, lat1);
        send(1, 8'hB0, 1'b1, lat1);
      end
    join
    wait_idle("cont_idle");
    sb_check("cont");

    // busy gating then timeout
    mode     = 1;
    man_busy = 1'b1;
    n0       = got_q.size();
    v0 = 1'b1; d0 = 8'h5A; l0 = 1'b1;
    exp_q.push_back(8'h5A);
    repeat (6) step;
    chk("gate_idle", arb_busy, 0);
    chk("gate_nowr", got_q.size(), n0);
    man_busy = 1'b0;
    step;
    chk("gate_wr_en", uart_wr_en, 1);
    chk("gate_ready", req_ready, 2'b01);
    v0 = 1'b0;
    v1 = 1'b1; d1 = 8'h6B; l1 = 1'b1;
    exp_q.push_back(8'h6B);
    k = 0;
    step;
    while (arb_busy && k < 40) begin
      k++;
      step;
    end
    chk("timeout_cycles", k, BT);
    step;
    chk("tmo_next_wr", uart_wr_en, 1);
    chk("tmo_next_rdy", req_ready, 2'b10);
    v1 = 1'b0;
    wait_idle("tmo_idle");
    sb_check("gate");

    // message lock
    mode = 0;
    do_reset;
`ifdef UART_ARB_LOCK_EN
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hD0);
`else
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hD0);
    exp_q.push_back(8'hC2);
    exp_q.push_back(8'hC3);
`endif
    fork
      begin
        send(1, 8'hC1, 1'b0, lat1);
        send(1, 8'hC2, 1'b0, lat1);
        send(1, 8'hC3, 1'b1, lat1);
      end
      begin
        step;
        send(0, 8'hD0, 1'b1, lat0);
      end
    join
    wait_idle("lock_idle");
    sb_check("lock");

    // reset mid-transfer
    exp_q.push_back(8'hE5);
    send(1, 8'hE5, 1'b1, lat);
    wait_busy(1'b1, "mid_rise");
    step;
    chk("mid_grant", grant_id, 1);
    chk("mid_arb", arb_busy, 1);
    mode     = 1;
    man_busy = 1'b0;
    rst      = 1'b1;
    v1 = 1'b1; d1 = 8'hF7; l1 = 1'b1;
    exp_q.push_back(8'hF7);
    #1;
    chk("mid_rst_wr_en", uart_wr_en, 0);
    chk("mid_rst_data", uart_wr_data, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_arb", arb_busy, 0);
    step;
    rst = 1'b0;
    step;
    chk("mid_fresh_wr", uart_wr_en, 1);
    chk("mid_fresh_data", uart_wr_data, 8'hF7);
    chk("mid_fresh_rdy", req_ready, 2'b10);
    v1 = 1'b0;
    wait_idle("mid_idle");
    sb_check("mid");
    chk("no_extra_bytes", got_q.size(), rd);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The module SHALL have parameter N_REQ, default 2, giving the number of byte requesters (2..8).
REQ-002 The module SHALL have parameter BUSY_TIMEOUT, default 16, giving the cycles to wait for uart_tx_busy to rise after a write.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester byte valid.
REQ-006 req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  input  N_REQ  marks the final byte of a message; used only when UART_ARB_LOCK_EN is defined.
REQ-008 req_ready  output  N_REQ  one-cycle byte-accept strobe, one-hot or zero.
REQ-009 uart_wr_en  output  1  one-cycle write strobe to the UART transmitter.
REQ-010 uart_wr_data  output  8  byte presented with uart_wr_en.
REQ-011 uart_tx_busy  input  1  UART transmitter busy.
REQ-012 grant_id  output  max(1,$clog2(N_REQ))  index of the current or last winner.
REQ-013 arb_busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT_RISE and WAIT_FALL.
REQ-015 IDLE: if any eligible req_valid is high and uart_tx_busy=0, the FSM SHALL register the round-robin winner into grant_id and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-016 Round-robin priority SHALL search from the pointer upward with wrap-around (N_REQ-1 -> 0); the pointer SHALL move to winner+1 mod N_REQ on every accepted byte.
REQ-017 ISSUE lasts exactly one cycle: uart_wr_en=1, uart_wr_data=req_data[grant_id], req_ready[grant_id]=1; next state WAIT_RISE.
REQ-018 Requesters SHALL hold req_valid and req_data stable until req_ready; the byte is consumed only on the req_ready cycle.
REQ-019 Latency: eligible valid sampled in IDLE at edge t SHALL produce uart_wr_en in the cycle following edge t, i.e. one cycle.
REQ-020 WAIT_RISE: uart_tx_busy=1 SHALL go to WAIT_FALL; a timeout counter reaching BUSY_TIMEOUT SHALL go to IDLE; the counter SHALL clear on entry.
REQ-021 WAIT_FALL: uart_tx_busy=0 SHALL go to IDLE.
REQ-022 Simultaneous valids SHALL yield exactly one winner; losers SHALL see req_ready=0 and keep waiting.
REQ-023 A requester dropping req_valid before it is granted SHALL lose no state; a new winner SHALL be chosen next IDLE cycle.
REQ-024 uart_wr_data SHALL be 8'h00 whenever uart_wr_en=0.

Reset
REQ-025 rst high SHALL immediately force state IDLE, uart_wr_en=0, uart_wr_data=0, req_ready=0, grant_id=0, arb_busy=0, pointer=0, timeout counter=0, and lock cleared.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer; after release the FSM SHALL restart from IDLE regardless of uart_tx_busy history.

Configuration
REQ-027 With UART_ARB_LOCK_EN defined, a byte accepted with req_last=0 SHALL set a lock making only grant_id eligible and freezing the pointer; accepting a byte with req_last=1 SHALL clear the lock and advance the pointer.
REQ-028 Without UART_ARB_LOCK_EN, req_last SHALL be ignored and arbitration SHALL be per byte.

Structure
REQ-029 The FSM state enum, its width and the default BUSY_TIMEOUT SHALL live in package uart_arb_pkg.
REQ-030 The rotating priority search SHALL be a sub-module rr_pick (inputs: request vector, pointer; outputs: any, winner index).

Verification
REQ-031 Single request: req_valid[0]=1, data 8'h41, busy rising 2 cycles after the strobe -> one uart_wr_en with 8'h41, req_ready[0] for one cycle, arb_busy until busy falls.
REQ-032 Contention: N_REQ=2, both valid continuously, data 8'hA0/8'hB0 -> bytes alternate A0,B0,A0,B0 starting from requester 0 after reset.
REQ-033 Busy gating: uart_tx_busy held 1 while valid -> no uart_wr_en until busy=0, then wr_en the next cycle.
REQ-034 Timeout: busy never rises -> return to IDLE exactly BUSY_TIMEOUT cycles after entering WAIT_RISE, and the next byte is then issued.
REQ-035 Lock (UART_ARB_LOCK_EN): requester 1 sends 3 bytes with req_last on the third while requester 0 is valid -> all 3 bytes from 1 first, then requester 0; without the macro -> interleaved.
REQ-036 Reset mid-transfer: rst pulsed in WAIT_FALL -> all outputs 0 immediately; after release with busy=0 and valid high -> a fresh wr_en one cycle later.
